// File: rtl/display_pkg.sv
// Shared types and default timing constants for the display scan blocks.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } scan_state_t;

  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_BLANK_CYCLES = 16;
  localparam int DEF_PWM_W        = 4;

endpackage

// File: rtl/digit_rr_select.sv
// Rotating-priority finder: first set mask bit at or after cur
// (include_cur=1) or strictly after cur, wrapping back to cur last.
module digit_rr_select #(
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             include_cur,
  output logic [SEL_W-1:0] nxt,
  output logic             valid
);

  // Descending scan so the nearest candidate is the last one written.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int sum;
      logic [SEL_W-1:0] idx;
      sum = int'(cur) + i + (include_cur ? 0 : 1);
      if (sum >= N) sum = sum - N;
      idx = SEL_W'(sum);
      if (mask[idx]) begin
        nxt   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with skip mask,
// anti-ghosting blank interval and PWM brightness.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int PWM_W        = DEF_PWM_W,
  localparam int SEL_W = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  input  logic [PWM_W-1:0]      brightness,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEL_W-1:0]      dsp_sel,
  output logic                  slot_start
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] BLANK_LAST =
    PRE_W'(BLANK_CYCLES - 1);
  localparam logic [PRE_W-1:0] SLOT_LAST =
    PRE_W'(PRESCALE - 1);

  scan_state_t state, state_nxt;

  logic [PRE_W-1:0]      pre_cnt, pre_nxt;
  logic [PWM_W-1:0]      pwm_cnt, pwm_nxt;
  logic [SEL_W-1:0]      sel_nxt;
  logic                  start_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  logic [SEL_W-1:0] rr_cur;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_incl;
  logic             rr_valid;

  // Leaving IDLE searches from digit 0 inclusive; slot ends search past dsp_sel.
  assign rr_incl = (state == IDLE);
  assign rr_cur  = rr_incl ? '0 : dsp_sel;

  digit_rr_select #(
    .N(NUM_DIGITS)
  ) u_rr (
    .mask        (digit_mask),
    .cur         (rr_cur),
    .include_cur (rr_incl),
    .nxt         (rr_idx),
    .valid       (rr_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    pwm_nxt   = pwm_cnt;
    sel_nxt   = dsp_sel;
    start_nxt = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      pre_nxt   = '0;
      pwm_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = BLANK;
          pre_nxt   = '0;
          pwm_nxt   = '0;
          start_nxt = 1'b1;
          if (rr_valid) sel_nxt = rr_idx;
        end
        BLANK: begin
          pre_nxt = pre_cnt + PRE_W'(1);
          if (pre_cnt == BLANK_LAST) state_nxt = ON;
        end
        ON: begin
          if (pre_cnt == SLOT_LAST) begin
            state_nxt = BLANK;
            pre_nxt   = '0;
            pwm_nxt   = '0;
            start_nxt = 1'b1;
            if (rr_valid) sel_nxt = rr_idx;
          end else begin
            pre_nxt = pre_cnt + PRE_W'(1);
            pwm_nxt = pwm_cnt + PWM_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Anodes are computed from next-state values so they stay registered.
  always_comb begin
    an_nxt = '1;
    if (state_nxt == ON && digit_mask[sel_nxt] &&
        (brightness == '1 || pwm_nxt < brightness))
      an_nxt[sel_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      dsp_sel    <= '0;
      an         <= '1;
      slot_start <= 1'b0;
    end else begin
      pre_cnt    <= pre_nxt;
      pwm_cnt    <= pwm_nxt;
      dsp_sel    <= sel_nxt;
      an         <= an_nxt;
      slot_start <= start_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a slot-position model pushes
// expected outputs each edge; a negedge monitor pops and compares.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int PS  = 8;
  localparam int BL  = 2;
  localparam int PW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [ND-1:0] digit_mask = 4'b1111;
  logic [PW-1:0] brightness = 2'd3;
  logic [ND-1:0] an;
  logic [1:0]    dsp_sel;
  logic          slot_start;

  int n_cmp = 0;
  int n_err = 0;
  bit skip_mode = 0;
  int skip_bad = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [1:0] sel;
    logic       st;
  } exp_t;

  exp_t q[$];

  bit         m_act = 0;
  int         m_pos = 0;
  logic [1:0] m_sel = 2'd0;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BL),
    .PWM_W        (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .brightness (brightness),
    .an         (an),
    .dsp_sel    (dsp_sel),
    .slot_start (slot_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr(input logic [3:0] m,
                                    input logic [1:0] cur,
                                    input bit incl, output bit ok);
    rr = cur;
    ok = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (int'(cur) + k + (incl ? 0 : 1)) % 4;
      if (!ok && m[j]) begin
        rr = 2'(j);
        ok = 1;
      end
    end
  endfunction

  // Reference: position within slot, PWM phase derived from position.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0;
      m_pos = 0;
      m_sel = 2'd0;
      q.delete();
    end else begin
      exp_t e;
      bit ok;
      logic [1:0] s;
      int pwm;
      e.st = 1'b0;
      if (!en) begin
        m_act = 0;
        m_pos = 0;
      end else if (!m_act) begin
        m_act = 1;
        m_pos = 0;
        s = rr(digit_mask, 2'd0, 1'b1, ok);
        if (ok) m_sel = s;
        e.st = 1'b1;
      end else if (m_pos == PS - 1) begin
        m_pos = 0;
        s = rr(digit_mask, m_sel, 1'b0, ok);
        if (ok) m_sel = s;
        e.st = 1'b1;
      end else begin
        m_pos++;
      end
      e.an = 4'b1111;
      pwm = (m_pos - BL) % 4;
      if (m_act && m_pos >= BL && digit_mask[m_sel] &&
          (brightness == 2'd3 || pwm < int'(brightness)))
        e.an[m_sel] = 1'b0;
      e.sel = m_sel;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_an", 32'(an), 32'(e.an));
      chk("sb_sel", 32'(dsp_sel), 32'(e.sel));
      chk("sb_start", 32'(slot_start), 32'(e.st));
    end
    if (skip_mode && (an == 4'b1110 || an == 4'b1011)) skip_bad++;
  end

  task automatic wait_start(output logic [1:0] s, output int cyc);
    bit seen;
    seen = 0;
    s = 2'd0;
    cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (slot_start === 1'b1) begin
        seen = 1;
        s = dsp_sel;
      end
    end
    if (!seen) chk("start_timeout", 32'(seen), 32'd1);
  endtask

  task automatic count_an(input logic [3:0] pat, output int c);
    c = (an == pat) ? 1 : 0;
    repeat (PS - 1) begin
      @(negedge clk);
      if (an == pat) c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s;
    int cyc;
    int c;
    int nst;
    logic [1:0] basic_seq [5];
    logic [1:0] skip_seq [3];
    basic_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    skip_seq  = '{2'd1, 2'd3, 2'd1};

    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sel", 32'(dsp_sel), 32'd0);
    chk("rst_start", 32'(slot_start), 32'd0);
    #1 rst = 1'b0;
    en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      wait_start(s, cyc);
      chk("basic_sel", 32'(s), 32'(basic_seq[i]));
      if (i > 0) chk("period", 32'(cyc), 32'(PS));
    end

    #1 digit_mask = 4'b1010;
    skip_mode = 1;
    for (int i = 0; i < 3; i++) begin
      wait_start(s, cyc);
      chk("skip_sel", 32'(s), 32'(skip_seq[i]));
    end
    skip_mode = 0;
    chk("skip_an", 32'(skip_bad), 32'd0);

    #1 digit_mask = 4'b0001;
    brightness = 2'd1;
    wait_start(s, cyc);
    chk("pwm1_sel", 32'(s), 32'd0);
    count_an(4'b1110, c);
    chk("pwm1_on", 32'(c), 32'd2);
    #1 brightness = 2'd0;
    wait_start(s, cyc);
    count_an(4'b1111, c);
    chk("pwm0_dark", 32'(c), 32'(PS));

    #1 brightness = 2'd3;
    digit_mask = 4'b0110;
    wait_start(s, cyc);
    chk("en_sel", 32'(s), 32'd1);
    repeat (4) @(negedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    chk("en_off_an", 32'(an), 32'hF);
    nst = 0;
    repeat (20) begin
      @(negedge clk);
      if (slot_start) nst++;
    end
    chk("en_off_nostart", 32'(nst), 32'd0);
    #1 en = 1'b1;
    wait_start(s, cyc);
    chk("restart_sel", 32'(s), 32'd1);
    chk("restart_lat", 32'(cyc), 32'd1);

    #1 digit_mask = 4'b0000;
    wait_start(s, cyc);
    chk("empty_sel", 32'(s), 32'd1);
    chk("empty_period", 32'(cyc), 32'(PS));
    count_an(4'b1111, c);
    chk("empty_dark", 32'(c), 32'(PS));

    #1 digit_mask = 4'b1111;
    wait_start(s, cyc);
    chk("resume_sel", 32'(s), 32'd2);
    repeat (3) @(negedge clk);
    chk("on_an", 32'(an), 32'b1011);
    #1 digit_mask = 4'b1011;
    @(negedge clk);
    chk("clr_an", 32'(an), 32'hF);
    wait_start(s, cyc);
    chk("clr_next_sel", 32'(s), 32'd3);

    digit_mask = 4'b1111;
    repeat (4) @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'b0111);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_sel", 32'(dsp_sel), 32'd0);
    chk("arst_start", 32'(slot_start), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_start(s, cyc);
    chk("post_rst_sel", 32'(s), 32'd0);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Parametrised multiplexed seven-segment scan controller. It drives the active-low digit anodes and the binary digit-select that steers the segment mux, for NUM_DIGITS digits. It adds a per-digit skip mask, an anti-ghosting blank interval at the start of each digit slot, and PWM brightness control. It sits between the board-level segment decoder/mux and the digit anode pins, and replaces the fixed 4-digit flop ring.

## Interface
- NUM_DIGITS, 4: number of digits scanned (2..16).
- SEL_W, $clog2(NUM_DIGITS): digit-select width (derived localparam, not overridden).
- PRESCALE, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off (≥1).
- PWM_W, 4: brightness resolution in bits.

Ports:
- clk  in  1  system clock; one clock domain; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces idle.
- digit_mask  in  NUM_DIGITS  1 = digit participates in scan, 0 = skipped.
- brightness  in  PWM_W  on-time duty; all-ones = fully on.
- an  out  NUM_DIGITS  anode drives, active-low, registered.
- dsp_sel  out  SEL_W  index of the current digit, registered.
- slot_start  out  1  one-cycle pulse in the first cycle of each slot.

## Operation
- States: IDLE, BLANK, ON.
- Internal counters:
  - pre_cnt, $clog2(PRESCALE) bits: slot position.
  - pwm_cnt, PWM_W bits: free-running during ON, wraps.
- IDLE: an all ones, counters cleared, dsp_sel held. Leaves to BLANK when en=1. The first digit is found by searching upward from index 0, inclusive.
- BLANK: covers pre_cnt 0..BLANK_CYCLES-1. an all ones. Goes to ON when pre_cnt=BLANK_CYCLES-1.
- ON: covers pre_cnt BLANK_CYCLES..PRESCALE-1.
  - an[dsp_sel]=0 when (pwm_cnt < brightness) or brightness = all-ones, and digit_mask[dsp_sel]=1. All other bits are 1.
  - brightness=0 gives dark.
- Slot end (pre_cnt=PRESCALE-1):
  - pre_cnt and pwm_cnt clear.
  - State goes to BLANK.
  - dsp_sel advances to the next set mask bit searching cyclically from dsp_sel+1. It wraps NUM_DIGITS-1→0, and returns to itself if it is the only set bit.
  - slot_start=1.
- digit_mask all zero: dsp_sel holds, an stays all ones, slot timing and slot_start continue.
- en deasserted in any state: IDLE on the next cycle, an all ones that cycle.
- Mask changes:
  - Slot advance uses the mask at the boundary cycle.
  - Clearing the current digit's bit mid-slot turns its anode off on the next cycle.
- brightness is sampled every cycle, with no glitch protection.
- Never more than one an bit low.

## Timing
- Reset values: an='1, dsp_sel=0, slot_start=0, state=IDLE, counters 0.
- en sampled high in IDLE at cycle T:
  - At T+1: state BLANK, pre_cnt=0, dsp_sel = first active digit, slot_start=1.
  - First possible an low at T+1+BLANK_CYCLES.
- Slot period is exactly PRESCALE cycles; slot_start pulses once per period.
- Output latency: an and dsp_sel reflect the state register with no combinational path from inputs to outputs.
- Reset asserted mid-slot: outputs return to reset values immediately (asynchronously).

## Structure
- Package display_pkg:
  - scan_state_t enum {IDLE, BLANK, ON}.
  - Default constants for PRESCALE, BLANK_CYCLES and PWM_W.
- One sub-module, digit_rr_select: combinational rotating-priority finder. It takes (mask, cur, include_cur) and returns next index plus a valid flag. It is reused by future multi-channel display blocks.
- All counters and the FSM live in display_scan_ctrl.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, PWM_W=2.
- Basic scan: reset, then en=1, mask=4'b1111, brightness=3.
  - dsp_sel sequence 0,1,2,3,0.
  - an per slot: 2 cycles 4'b1111 then 6 cycles one-hot-low (4'b1110 for digit 0).
  - slot_start every 8 cycles.
- Skip mask: mask=4'b1010 → dsp_sel alternates 1,3,1; an is never 4'b1110 or 4'b1011.
- PWM: brightness=1, mask=4'b0001 → in each ON phase an=4'b1110 on pwm_cnt 0 only (cycles 0 and 4 of ON); brightness=0 → an stays 4'b1111.
- Enable/empty mask:
  - Drop en mid-ON → an=4'b1111 next cycle, no further slot_start.
  - Re-raise en → restart from lowest set digit.
  - mask=0 → an all ones, slot_start continues, dsp_sel held.
- Async reset: assert rst between clock edges mid-ON → an=4'b1111 and dsp_sel=0 before the next edge.
- Mid-slot mask clear: clear the current digit's mask bit during ON → its anode goes high the following cycle; next slot selects the next set bit.
